// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

    // Default datapath width of the CPU ALU.
    localparam int unsigned DATA_WIDTH = 8;

    // Divider control states.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/seq_divider_div_sub_stage.sv
// Combinational (WIDTH+1)-bit subtract stage; ge is the inverted borrow.
module div_sub_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           ge
);

    logic borrow;

    // One extra bit on the subtract exposes the borrow as the compare result.
    always_comb begin
        {borrow, diff} = {1'b0, a} - {1'b0, b};
        ge             = ~borrow;
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle, MSB first.
// Optional macro SEQ_DIV_ZERO_TRAP_EN: short-circuits divide-by-zero and raises div_err.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend bits shifted out, quotient bits shifted in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder
    logic [WIDTH-1:0] quo_d, remo_d;
    logic             busy_d, done_d;
`ifdef SEQ_DIV_ZERO_TRAP_EN
    logic             err_q, err_d;
`endif

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // Partial remainder shifted left with the next dividend bit appended.
    assign trial = {rem_q, dvd_q[WIDTH-1]};

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .a    (trial),
        .b    ({1'b0, dvs_q}),
        .diff (diff),
        .ge   (ge)
    );

    // Restore on borrow, otherwise keep the difference; the quotient bit is the compare.
    always_comb begin
        rem_next = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next = {dvd_q[WIDTH-2:0], ge};
    end

    // Next-state and register-input logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quotient;
        remo_d  = remainder;
        busy_d  = busy;
        done_d  = done;
`ifdef SEQ_DIV_ZERO_TRAP_EN
        err_d   = err_q;
`endif
        case (state_q)
            DIV_IDLE, DIV_DONE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    quo_d   = '0;
                    remo_d  = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = DIV_CALC;
`ifdef SEQ_DIV_ZERO_TRAP_EN
                    err_d   = 1'b0;
                    if (divisor == '0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        quo_d   = {WIDTH{1'b1}};
                        remo_d  = dividend;
                        state_d = DIV_DONE;
                    end
`endif
                end
            end
            DIV_CALC: begin
                dvd_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = quo_next;
                    remo_d  = rem_next;
                    state_d = DIV_DONE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_DIV_ZERO_TRAP_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quotient  <= quo_d;
            remainder <= remo_d;
            busy      <= busy_d;
            done      <= done_d;
`ifdef SEQ_DIV_ZERO_TRAP_EN
            err_q     <= err_d;
`endif
        end
    end

`ifdef SEQ_DIV_ZERO_TRAP_EN
    assign div_err = err_q;
`else
    assign div_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random self-checking bench for seq_divider (WIDTH=8).
module tb_seq_divider;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_err   (div_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one division and check latency, busy width and results.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input int exp_edges, input int exp_busy,
                           input logic exp_err, input bit inject);
        int edges;
        int busy_cnt;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = b + 8'd1;
        edges    = 1;
        busy_cnt = 0;
        if (exp_busy > 0) begin
            chk({tag, " q_busy"}, quotient, 0);
            chk({tag, " r_busy"}, remainder, 0);
        end
        while (!done && edges < 20) begin
            if (busy) busy_cnt++;
            if (inject && edges == 3) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        chk({tag, " done"}, done, 1);
        chk({tag, " edges"}, edges, exp_edges);
        chk({tag, " busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, " busy_end"}, busy, 0);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_err"}, div_err, exp_err);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           f0;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2;
        chk("rst quotient", quotient, 0);
        chk("rst remainder", remainder, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst div_err", div_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1. basic division
        run_div("t1 200/7", 8'd200, 8'd7, 8'd28, 8'd4, 9, 8, 1'b0, 1'b0);

        // 2. all-ones quotient, then back-to-back divisor > dividend
        run_div("t2 255/1", 8'd255, 8'd1, 8'd255, 8'd0, 9, 8, 1'b0, 1'b0);
        chk("t2 done_hold", done, 1);
        run_div("t2 5/10", 8'd5, 8'd10, 8'd0, 8'd5, 9, 8, 1'b0, 1'b0);

        // 3. start while busy is ignored
        run_div("t3 200/7 inj", 8'd200, 8'd7, 8'd28, 8'd4, 9, 8, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("t3 hold q", quotient, 28);
        chk("t3 hold done", done, 1);

        // 4. reset mid-calculation aborts
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t4 busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("t4 rst busy", busy, 0);
        chk("t4 rst done", done, 0);
        chk("t4 rst quotient", quotient, 0);
        chk("t4 rst remainder", remainder, 0);
        chk("t4 rst div_err", div_err, 0);
        @(negedge clk);
        rst = 1'b0;
        run_div("t4 100/3", 8'd100, 8'd3, 8'd33, 8'd1, 9, 8, 1'b0, 1'b0);

        // 5. divide by zero
`ifdef SEQ_DIV_ZERO_TRAP_EN
        run_div("t5 77/0", 8'd77, 8'd0, 8'd255, 8'd77, 1, 0, 1'b1, 1'b0);
`else
        run_div("t5 77/0", 8'd77, 8'd0, 8'd255, 8'd77, 9, 8, 1'b0, 1'b0);
`endif

        // 6. random sweep against the arithmetic operators
        for (int i = 0; i < 256; i++) begin
            a  = W'($urandom_range(255));
            b  = W'($urandom_range(255, 1));
            f0 = failures;
            run_div("sweep", a, b, a / b, a % b, 9, 8, 1'b0, 1'b0);
            if (failures == f0)
                $display("sweep %0d: %0d/%0d = %0d r %0d Passed", i, a, b, quotient, remainder);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
